smz_cfg_ctrl: RTL and testbench
===============================

Name: smz_cfg_ctrl

Overview:
AXI4-lite slave register block that configures the secure memory zone (SMZ) window of the encrypting memory model. It drives smz_base, smz_size and smz_enable. Software programs shadow registers, then issues a commit. A sequencer waits for the memory to go idle, validates the window and applies it atomically, so the zone never changes mid-transaction. A sticky lock freezes the configuration until reset.

Parameters:
ADDR_W, 8, register-space address width (offsets 0x00-0x14 used)
RESET_BASE, 32'h1000_0000, smz_base after reset
RESET_SIZE, 32'h0001_0000, smz_size after reset
RESET_ENABLE, 1, smz_enable after reset
MIN_SIZE, 4, smallest legal window in bytes (power of two)
IDLE_TIMEOUT, 1024, cycles to wait for mem_idle before aborting a commit

Ports:
clk  in  1  clock
resetn  in  1  reset (interface decided: reset resetn, synchronous, active-low; clock clk)
s_awvalid/s_awready  in/out  1  write address handshake
s_awaddr  in  ADDR_W  write byte offset
s_wvalid/s_wready  in/out  1  write data handshake
s_wdata  in  32  write data
s_wstrb  in  4  byte strobes
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_bresp  out  2  00 OKAY, 10 SLVERR
s_arvalid/s_arready  in/out  1  read address handshake
s_araddr  in  ADDR_W  read byte offset
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
s_rdata  out  32  read data
s_rresp  out  2  always 00
mem_idle  in  1  memory has no outstanding AXI transaction
smz_base  out  32  active window base
smz_size  out  32  active window size
smz_enable  out  1  active enable
cfg_done  out  1  one-cycle pulse when a commit applies or aborts

Behaviour:
- Reset state: all ready/valid outputs 0; rdata 0; bresp 00; smz_* set to RESET_*; shadows equal to the active values; lock 0; status 0; FSM IDLE.
- Register map:
  - 0x00 CTRL RW: bit0 en_shadow, bit1 lock_shadow, bit8 commit (write-1, reads 0).
  - 0x04 BASE_SH RW.
  - 0x08 SIZE_SH RW.
  - 0x0C STATUS: bit0 active enable, bit1 locked, bit2 pending, bit3 cfg_err (W1C), bit4 timeout (W1C).
  - 0x10 ACT_BASE RO.
  - 0x14 ACT_SIZE RO.
  - Other offsets read 0; writes to them return SLVERR.
- Write channel:
  - Accept only when awvalid and wvalid are both high and bvalid is 0.
  - awready and wready pulse together for one cycle.
  - Registers update on that edge, per byte under wstrb.
  - bvalid rises on the next cycle and is held until bready.
- Read channel:
  - arready pulses for one cycle when arvalid is high and rvalid is 0.
  - rvalid and rdata follow on the next cycle and are held until rready.
- Simultaneous read and write are served in parallel; the read returns the pre-write value.
- SLVERR cases (register unchanged): write to CTRL, BASE_SH or SIZE_SH while locked or while pending. STATUS W1C writes are always allowed.
- Commit is triggered by a write with wstrb[1]=1 and wdata[8]=1 to CTRL. It sets pending; the FSM moves IDLE -> WAIT_IDLE.
- WAIT_IDLE:
  - The timeout counter starts at 0 and increments each cycle.
  - If mem_idle=1: go to APPLY.
  - If the counter reaches IDLE_TIMEOUT-1 first: set timeout, clear pending, pulse cfg_done, return to IDLE with active values unchanged.
- APPLY (one cycle):
  - Valid if en_shadow=0, or all of: SIZE_SH is a power of two, SIZE_SH >= MIN_SIZE, (BASE_SH & (SIZE_SH-1)) == 0, and BASE_SH+SIZE_SH computed in 33 bits is <= 2^32-1.
  - Valid: on the next edge copy the shadows to smz_*; locked |= lock_shadow.
  - Invalid: set cfg_err and leave smz_* unchanged.
  - In both cases clear pending, pulse cfg_done, return to IDLE.
  - When en_shadow=0 only smz_enable changes to 0; base and size are still copied.
- smz_* change only in the APPLY cycle, and only while mem_idle was seen high the cycle before.
- Reset mid-commit aborts the commit: outputs return to RESET_*, lock is cleared, no cfg_done.

Decomposition:
- Package smz_cfg_pkg holds:
  - register offset constants;
  - CTRL and STATUS bit indices;
  - FSM state enum (IDLE, WAIT_IDLE, APPLY);
  - AXI response codes.
- One sub-module, smz_window_check: combinational validity of base/size/min_size, instantiated in APPLY.

Test Plan:
- Reset, then read 0x10/0x14/0x0C -> 0x1000_0000, 0x0001_0000, STATUS=0x1.
- Write BASE_SH=0x0000_8000, SIZE_SH=0x0000_4000, CTRL=0x101 with mem_idle=1 -> cfg_done within 3 cycles after B; smz_base=0x8000, smz_size=0x4000, enable=1.
- Misaligned commit (BASE_SH=0x0000_8100, SIZE_SH=0x1000, CTRL=0x101) -> STATUS.cfg_err=1; smz_* unchanged; W1C 0x8 to STATUS clears it.
- mem_idle held 0 for 1500 cycles after commit -> STATUS.timeout=1 at cycle 1024; write to BASE_SH during pending gets bresp=SLVERR.
- Commit CTRL=0x103 -> locked=1; subsequent BASE_SH write gets SLVERR and a readback shows the old value; resetn low clears the lock.
- Simultaneous AR to STATUS and AW/W W1C to STATUS with cfg_err set -> read returns cfg_err=1; a following read returns 0; bready held low 5 cycles keeps bvalid=1 stable.

Source files
------------

// File: rtl/smz_cfg_pkg.sv
// Shared constants for the SMZ window configuration block: register offsets,
// CTRL/STATUS bit positions, sequencer states and AXI response codes.
package smz_cfg_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_BASE_SH  = 8'h04;
  localparam logic [7:0] OFF_SIZE_SH  = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_ACT_BASE = 8'h10;
  localparam logic [7:0] OFF_ACT_SIZE = 8'h14;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOCK   = 1;
  localparam int CTRL_COMMIT = 8;

  localparam int ST_ENABLE  = 0;
  localparam int ST_LOCKED  = 1;
  localparam int ST_PENDING = 2;
  localparam int ST_CFG_ERR = 3;
  localparam int ST_TIMEOUT = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_IDLE = 2'd1,
    APPLY     = 2'd2
  } cfg_state_e;

  // Byte-lane merge of a write into an existing 32-bit register value.
  function automatic logic [31:0] merge_wstrb(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/smz_window_check.sv
// Combinational legality check of a candidate SMZ window. A disabled window is
// always accepted; an enabled one must be a naturally aligned power-of-two
// region of at least MIN_SIZE bytes that does not reach past 2^32-1.
module smz_window_check #(
  parameter int unsigned MIN_SIZE = 4
) (
  input  logic        en,
  input  logic [31:0] base,
  input  logic [31:0] size,
  output logic        valid
);

  logic [32:0] end_sum;
  logic [31:0] size_m1;
  logic        pow2;
  logic        big_enough;
  logic        aligned;
  logic        no_wrap;

  // Evaluate each window rule independently, then combine.
  always_comb begin
    size_m1    = size - 32'd1;
    end_sum    = {1'b0, base} + {1'b0, size};
    pow2       = (size != 32'd0) && ((size & size_m1) == 32'd0);
    big_enough = size >= 32'(MIN_SIZE);
    aligned    = (base & size_m1) == 32'd0;
    // base+size == 2^32 also sets the carry, so a window touching the very
    // top of the address space is rejected.
    no_wrap    = !end_sum[32];
    valid      = !en || (pow2 && big_enough && aligned && no_wrap);
  end

endmodule

// File: rtl/smz_cfg_ctrl.sv
// AXI4-lite register block for the secure memory zone window. Software writes
// shadow registers and requests a commit; the sequencer waits for the memory
// to go idle, validates the window and swaps it in atomically.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | no commit in flight; shadows writable unless locked
//  WAIT_IDLE | commit requested; waiting for mem_idle or the timeout
//  APPLY     | memory seen idle last cycle; validate and copy shadows
module smz_cfg_ctrl
  import smz_cfg_pkg::*;
#(
  parameter int          ADDR_W       = 8,
  parameter logic [31:0] RESET_BASE   = 32'h1000_0000,
  parameter logic [31:0] RESET_SIZE   = 32'h0001_0000,
  parameter logic        RESET_ENABLE = 1'b1,
  parameter int unsigned MIN_SIZE     = 4,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_wvalid,
  output logic              s_wready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  output logic              s_bvalid,
  input  logic              s_bready,
  output logic [1:0]        s_bresp,
  input  logic              s_arvalid,
  output logic              s_arready,
  input  logic [ADDR_W-1:0] s_araddr,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  input  logic              mem_idle,
  output logic [31:0]       smz_base,
  output logic [31:0]       smz_size,
  output logic              smz_enable,
  output logic              cfg_done
);

  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IDLE_TIMEOUT - 1);

  cfg_state_e       state;
  logic [CNT_W-1:0] wait_cnt;

  logic        en_sh;
  logic        lock_sh;
  logic [31:0] base_sh;
  logic [31:0] size_sh;

  logic locked;
  logic pending;
  logic cfg_err;
  logic timeout;

  logic        busy;
  logic        wr_fire;
  logic        wr_err;
  logic        wr_ctrl;
  logic        wr_base;
  logic        wr_size;
  logic        commit_req;
  logic        clr_err;
  logic        clr_to;
  logic [31:0] status_word;
  logic [31:0] rd_mux;
  logic        win_ok;

  // Both write channels are accepted together, so one ready serves both.
  assign s_wready = s_awready;
  assign s_rresp  = RESP_OKAY;
  assign busy     = locked || pending;

  smz_window_check #(
    .MIN_SIZE (MIN_SIZE)
  ) u_win (
    .en    (en_sh),
    .base  (base_sh),
    .size  (size_sh),
    .valid (win_ok)
  );

  // Decode the accepted write into register updates, commit and W1C strobes.
  always_comb begin
    wr_fire    = s_awready && s_awvalid && s_wvalid;
    wr_err     = 1'b0;
    wr_ctrl    = 1'b0;
    wr_base    = 1'b0;
    wr_size    = 1'b0;
    commit_req = 1'b0;
    clr_err    = 1'b0;
    clr_to     = 1'b0;
    if (wr_fire) begin
      case (s_awaddr)
        ADDR_W'(OFF_CTRL): begin
          if (busy) wr_err = 1'b1;
          else begin
            wr_ctrl    = 1'b1;
            commit_req = s_wstrb[1] && s_wdata[CTRL_COMMIT];
          end
        end
        ADDR_W'(OFF_BASE_SH): begin
          if (busy) wr_err = 1'b1;
          else      wr_base = 1'b1;
        end
        ADDR_W'(OFF_SIZE_SH): begin
          if (busy) wr_err = 1'b1;
          else      wr_size = 1'b1;
        end
        ADDR_W'(OFF_STATUS): begin
          clr_err = s_wstrb[0] && s_wdata[ST_CFG_ERR];
          clr_to  = s_wstrb[0] && s_wdata[ST_TIMEOUT];
        end
        ADDR_W'(OFF_ACT_BASE), ADDR_W'(OFF_ACT_SIZE): ;
        default: wr_err = 1'b1;
      endcase
    end
  end

  // Assemble STATUS and select the read data for the current read address.
  always_comb begin
    status_word             = '0;
    status_word[ST_ENABLE]  = smz_enable;
    status_word[ST_LOCKED]  = locked;
    status_word[ST_PENDING] = pending;
    status_word[ST_CFG_ERR] = cfg_err;
    status_word[ST_TIMEOUT] = timeout;
    rd_mux = '0;
    case (s_araddr)
      ADDR_W'(OFF_CTRL): begin
        rd_mux[CTRL_EN]   = en_sh;
        rd_mux[CTRL_LOCK] = lock_sh;
      end
      ADDR_W'(OFF_BASE_SH):  rd_mux = base_sh;
      ADDR_W'(OFF_SIZE_SH):  rd_mux = size_sh;
      ADDR_W'(OFF_STATUS):   rd_mux = status_word;
      ADDR_W'(OFF_ACT_BASE): rd_mux = smz_base;
      ADDR_W'(OFF_ACT_SIZE): rd_mux = smz_size;
      default:               rd_mux = '0;
    endcase
  end

  // AXI handshakes, write response/read data holding and shadow registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s_awready <= 1'b0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      en_sh     <= RESET_ENABLE;
      lock_sh   <= 1'b0;
      base_sh   <= RESET_BASE;
      size_sh   <= RESET_SIZE;
    end else begin
      s_awready <= s_awvalid && s_wvalid && !s_bvalid && !s_awready;
      if (wr_fire) begin
        s_bvalid <= 1'b1;
        s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
      if (wr_ctrl && s_wstrb[0]) begin
        en_sh   <= s_wdata[CTRL_EN];
        lock_sh <= s_wdata[CTRL_LOCK];
      end
      if (wr_base) base_sh <= merge_wstrb(base_sh, s_wdata, s_wstrb);
      if (wr_size) size_sh <= merge_wstrb(size_sh, s_wdata, s_wstrb);

      s_arready <= s_arvalid && !s_rvalid && !s_arready;
      // rd_mux reflects register state before any write on this same edge.
      if (s_arready && s_arvalid) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_mux;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Commit sequencer: owns the active window, lock and status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      smz_base   <= RESET_BASE;
      smz_size   <= RESET_SIZE;
      smz_enable <= RESET_ENABLE;
      locked     <= 1'b0;
      pending    <= 1'b0;
      cfg_err    <= 1'b0;
      timeout    <= 1'b0;
      cfg_done   <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (clr_err) cfg_err <= 1'b0;
      if (clr_to)  timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (commit_req) begin
            pending  <= 1'b1;
            wait_cnt <= '0;
            state    <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (mem_idle) begin
            state <= APPLY;
          end else if (wait_cnt == LAST_CNT) begin
            timeout  <= 1'b1;
            pending  <= 1'b0;
            cfg_done <= 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        APPLY: begin
          if (win_ok) begin
            smz_base   <= base_sh;
            smz_size   <= size_sh;
            smz_enable <= en_sh;
            locked     <= locked || lock_sh;
          end else begin
            cfg_err <= 1'b1;
          end
          pending  <= 1'b0;
          cfg_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smz_cfg_ctrl.sv
// Directed bench for smz_cfg_ctrl: register access, commit/validate/apply,
// timeout, lock, W1C and response-channel holding.
module tb_smz_cfg_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_awvalid, s_awready;
  logic [7:0]  s_awaddr;
  logic        s_wvalid, s_wready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic        s_arvalid, s_arready;
  logic [7:0]  s_araddr;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        mem_idle;
  logic [31:0] smz_base, smz_size;
  logic        smz_enable, cfg_done;

  always #5 clk = ~clk;

  smz_cfg_ctrl dut (
    .clk(clk), .resetn(resetn),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .mem_idle(mem_idle),
    .smz_base(smz_base), .smz_size(smz_size), .smz_enable(smz_enable),
    .cfg_done(cfg_done)
  );

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (resetn && cfg_done) begin
    done_cnt <= done_cnt + 1;
    done_cyc <= cyc;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic axi_wr(input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    n = 0;
    while (s_awready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check_val("wr_awready_timeout", {31'd0, s_awready}, 32'd1);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    hs_cyc = cyc;
    n = 0;
    while (s_bvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check_val("wr_bvalid_timeout", {31'd0, s_bvalid}, 32'd1);
    resp = s_bresp;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [7:0] addr, output logic [31:0] data);
    int n;
    @(posedge clk); #1;
    s_araddr = addr; s_arvalid = 1'b1;
    n = 0;
    while (s_arready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check_val("rd_arready_timeout", {31'd0, s_arready}, 32'd1);
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    while (s_rvalid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n == 20) check_val("rd_rvalid_timeout", {31'd0, s_rvalid}, 32'd1);
    data = s_rdata;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Write shadows and commit with mem_idle high; return the commit handshake cycle.
  task automatic do_commit(input logic [31:0] base, input logic [31:0] size,
                           input logic [31:0] ctrl, output int c0);
    logic [1:0] r;
    axi_wr(8'h04, base, 4'hF, r);
    axi_wr(8'h08, size, 4'hF, r);
    axi_wr(8'h00, ctrl, 4'hF, r);
    c0 = hs_cyc;
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [31:0] win_base [8] = '{32'h0000_8000, 32'h0000_8100, 32'hFFFF_F000, 32'hFFFF_E000,
                                32'h0000_0000, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000};
  logic [31:0] win_size [8] = '{32'h0000_4000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000,
                                32'h0000_0002, 32'h0000_0004, 32'h0000_3000, 32'h0000_0000};
  logic        win_good [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [31:0] rd, rd2;
    logic [1:0]  resp;
    logic [31:0] m_base, m_size;
    int c0, d0, hold;

    resetn = 1'b0; mem_idle = 1'b1;
    s_awvalid = 0; s_awaddr = 0; s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_bready = 0;
    s_arvalid = 0; s_araddr = 0; s_rready = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // reset state
    check_val("rst_base", smz_base, 32'h1000_0000);
    check_val("rst_size", smz_size, 32'h0001_0000);
    check_val("rst_enable", {31'd0, smz_enable}, 32'd1);
    check_val("rst_valids", {28'd0, s_awready, s_bvalid, s_arready, s_rvalid}, 32'd0);
    check_val("rst_rdata", s_rdata, 32'd0);
    axi_rd(8'h10, rd); check_val("rst_act_base", rd, 32'h1000_0000);
    axi_rd(8'h14, rd); check_val("rst_act_size", rd, 32'h0001_0000);
    axi_rd(8'h0C, rd); check_val("rst_status", rd, 32'h0000_0001);
    axi_rd(8'h00, rd); check_val("rst_ctrl", rd, 32'h0000_0001);

    // byte strobes: only lane 1 of BASE_SH changes
    axi_wr(8'h04, 32'hAABB_CCDD, 4'b0010, resp);
    check_val("strb_resp", resp, 2'b00);
    axi_rd(8'h04, rd); check_val("strb_base_sh", rd, 32'h1000_CC00);

    // window legality table, mem_idle high
    m_base = 32'h1000_0000; m_size = 32'h0001_0000;
    for (int i = 0; i < 8; i++) begin
      d0 = done_cnt;
      do_commit(win_base[i], win_size[i], 32'h101, c0);
      if (win_good[i]) begin m_base = win_base[i]; m_size = win_size[i]; end
      check_val($sformatf("win%0d_done", i), done_cnt - d0, 1);
      check_val($sformatf("win%0d_lat", i), done_cyc - c0, 2);
      check_val($sformatf("win%0d_base", i), smz_base, m_base);
      check_val($sformatf("win%0d_size", i), smz_size, m_size);
      axi_rd(8'h0C, rd);
      check_val($sformatf("win%0d_status", i), rd, win_good[i] ? 32'h1 : 32'h9);
      axi_wr(8'h0C, 32'h18, 4'h1, resp);
    end
    axi_rd(8'h0C, rd); check_val("w1c_clear", rd, 32'h1);
    axi_rd(8'h00, rd); check_val("ctrl_commit_reads0", rd, 32'h1);

    // disabled window is always accepted; base/size still copied
    do_commit(32'h0, 32'h0, 32'h100, c0);
    check_val("dis_enable", {31'd0, smz_enable}, 32'd0);
    check_val("dis_size", smz_size, 32'h0);
    axi_rd(8'h0C, rd); check_val("dis_status", rd, 32'h0);
    do_commit(32'h8000, 32'h4000, 32'h101, c0);
    check_val("reen_enable", {31'd0, smz_enable}, 32'd1);
    check_val("reen_base", smz_base, 32'h8000);

    // timeout while memory stays busy
    mem_idle = 1'b0;
    d0 = done_cnt;
    axi_wr(8'h00, 32'h101, 4'hF, resp);
    c0 = hs_cyc;
    axi_rd(8'h0C, rd); check_val("pend_status", rd, 32'h5);
    axi_wr(8'h04, 32'h1111_0000, 4'hF, resp); check_val("pend_wr_slverr", resp, 2'b10);
    axi_rd(8'h04, rd); check_val("pend_base_kept", rd, 32'h8000);
    repeat (800) @(posedge clk);
    #1;
    check_val("to_early_done", done_cnt - d0, 0);
    axi_rd(8'h0C, rd); check_val("to_early_status", rd, 32'h5);
    repeat (700) @(posedge clk);
    #1;
    check_val("to_done", done_cnt - d0, 1);
    check_val("to_cycle", done_cyc - c0, 1024);
    check_val("to_base_kept", smz_base, 32'h8000);
    axi_rd(8'h0C, rd); check_val("to_status", rd, 32'h11);
    mem_idle = 1'b1;
    axi_wr(8'h0C, 32'h10, 4'h1, resp);
    axi_rd(8'h0C, rd); check_val("to_cleared", rd, 32'h1);

    // lock
    do_commit(32'h8000, 32'h4000, 32'h103, c0);
    axi_rd(8'h0C, rd); check_val("lock_status", rd, 32'h3);
    axi_wr(8'h04, 32'h1234_0000, 4'hF, resp); check_val("lock_base_slverr", resp, 2'b10);
    axi_rd(8'h04, rd); check_val("lock_base_kept", rd, 32'h8000);
    axi_wr(8'h00, 32'h101, 4'hF, resp); check_val("lock_ctrl_slverr", resp, 2'b10);
    axi_wr(8'h0C, 32'h18, 4'h1, resp); check_val("lock_w1c_okay", resp, 2'b00);
    do_reset();
    axi_rd(8'h0C, rd); check_val("unlock_status", rd, 32'h1);
    check_val("unlock_base", smz_base, 32'h1000_0000);
    axi_wr(8'h04, 32'h1000_0000, 4'hF, resp); check_val("unlock_wr_okay", resp, 2'b00);

    // simultaneous read and W1C of STATUS
    do_commit(32'h8100, 32'h1000, 32'h101, c0);
    fork
      axi_rd(8'h0C, rd);
      axi_wr(8'h0C, 32'h8, 4'h1, resp);
    join
    check_val("sim_rd_prewrite", rd, 32'h9);
    check_val("sim_wr_resp", resp, 2'b00);
    axi_rd(8'h0C, rd2); check_val("sim_rd_after", rd2, 32'h1);

    // bvalid held with bready low; unmapped offset
    @(posedge clk); #1;
    s_awaddr = 8'h18; s_wdata = 32'hFFFF_FFFF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    hold = 0;
    while (s_awready !== 1'b1 && hold < 20) begin @(posedge clk); #1; hold++; end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    hold = 0;
    for (int k = 0; k < 5; k++) begin
      if (s_bvalid === 1'b1 && s_bresp === 2'b10) hold++;
      @(posedge clk); #1;
    end
    check_val("bvalid_hold", hold, 5);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    check_val("bvalid_drop", {31'd0, s_bvalid}, 32'd0);
    axi_rd(8'h18, rd); check_val("unmapped_rd", rd, 32'h0);

    // reset in the middle of a commit
    mem_idle = 1'b0;
    axi_wr(8'h00, 32'h100, 4'hF, resp);
    d0 = done_cnt;
    repeat (5) @(posedge clk);
    do_reset();
    mem_idle = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("rstmid_no_done", done_cnt - d0, 0);
    check_val("rstmid_enable", {31'd0, smz_enable}, 32'd1);
    check_val("rstmid_base", smz_base, 32'h1000_0000);
    axi_rd(8'h0C, rd); check_val("rstmid_status", rd, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
